// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and baud arithmetic
// used by both the receive and transmit paths.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  function automatic int bit_period(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both stages reset
// to RST_VAL so the output is quiet coming out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronized line, one registered
// AXI4-Stream output slot, single-cycle frame_err / overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_wire,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int BIT_PERIOD  = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int BW          = $clog2(BIT_PERIOD);
  localparam int CW          = $clog2(DATA_WIDTH) + 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);

  uart_rx_state_t        state;
  logic [BW-1:0]         baud_cnt;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [DATA_WIDTH:0]   shift_ext;
  logic                  rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_wire),
    .q     (rx_s)
  );

  // New bit enters at the MSB so the first (LSB) bit ends up at bit 0.
  always_comb begin
    shift_ext  = {rx_s, shift_reg};
    shift_next = shift_ext[DATA_WIDTH:1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            // Leave at mid-stop-bit so a start bit right behind it is caught.
            baud_cnt <= '0;
            state    <= IDLE;
            if (!rx_s) begin
              frame_err <= 1'b1;
            end else if (!m_axis_tvalid || m_axis_tready) begin
              m_axis_tdata  <= shift_reg;
              m_axis_tvalid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
